vmem_arbiter: RTL and testbench
===============================

# vmem_arbiter

Arbitrates the shared video-memory port (VRAM $8000–$9FFF, OAM $FE00–$FE9F) between three requesters: the pixel processing unit, the OAM DMA engine and the CPU. Sits between the PPU/DMA/CPU-bus side and the single-port video BRAM. Enforces the mode-dependent CPU lockouts: OAM is locked in modes 2 and 3 and while DMA is active; VRAM is locked in mode 3. Issues at most one memory access per clock and returns read data to the winning requester after a fixed latency.

## Interface
Parameters:
- MEM_LATENCY, 2, clocks from a memory address being presented to `mem_rdata_in` being valid (1..4)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- mode_in  input  2  PPU mode: 0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw
- lcd_en_in  input  1  LCDC[7]; when 0, no CPU lockout applies
- dma_active_in  input  1  OAM DMA transfer in progress
- ppu_req_in / ppu_addr_in  input  1/16  PPU read request and address
- ppu_gnt_out / ppu_valid_out / ppu_data_out  output  1/1/8  PPU grant pulse, read-valid pulse, read data
- dma_req_in / dma_addr_in / dma_wdata_in  input  1/16/8  DMA OAM write request, address, data
- dma_gnt_out  output  1  DMA grant pulse (the write is done at grant)
- cpu_req_in / cpu_we_in / cpu_addr_in / cpu_wdata_in  input  1/1/16/8  CPU request, write enable, address, write data
- cpu_gnt_out / cpu_valid_out / cpu_data_out  output  1/1/8  CPU grant pulse, completion pulse (reads and writes), read data
- mem_en_out / mem_we_out / mem_addr_out / mem_wdata_out  output  1/1/16/8  BRAM port
- mem_rdata_in  input  8  BRAM read data

## Operation
- Handshake: a requester holds `req` and its address/data stable until it sees `gnt` high for one clock. It may raise the next `req` on the clock after the grant.
- Fixed priority each clock: PPU > DMA > CPU. Exactly one grant per clock at most. Losing requests stay pending and get no grant.
- CPU blocked when (`lcd_en_in` and region OAM and (mode is 2 or 3, or `dma_active_in`)), or when (`lcd_en_in` and region VRAM and mode is 3), or when the address is outside both regions.
- A blocked CPU request is still granted in arbitration order. It does not drive the memory port (`mem_en_out`=0). It completes on the normal schedule: reads return 8'hFF, writes are dropped.
- The blocking decision uses `mode_in` and `dma_active_in` sampled in the grant clock.
- PPU and DMA are never blocked. Region and mode are not checked for them.
- Response tracking uses a tag pipeline of depth MEM_LATENCY. Each tag is {valid, requester id, blocked}. The tag is pushed at grant. At tag exit:
  - PPU tag: `ppu_valid_out`=1 and `ppu_data_out`=`mem_rdata_in`.
  - CPU tag: `cpu_valid_out`=1, with `cpu_data_out`=`mem_rdata_in`, or 8'hFF if blocked.
  - DMA tag: no response is produced.
- Data outputs hold their last value between valid pulses.

## Timing
- Grant is combinational from the requests but registered to the outputs. The memory address is driven in the same clock as the grant (grant clock G).
- Read data is valid at G+MEM_LATENCY. The valid pulse lasts one clock. Back-to-back grants give back-to-back valid pulses (full throughput).
- Reset values: all gnt, valid, `mem_en_out` and `mem_we_out` are 0; data outputs are 8'h00; `mem_addr_out` is 16'h0000; the tag pipeline is cleared.
- Reset mid-operation drops in-flight responses. No valid pulse is emitted for any grant issued before reset.
- If a mode change lands in the same clock as a CPU grant, the blocking decision uses the pre-change `mode_in` value sampled in that clock.
- Simultaneous PPU and CPU requests every clock starve the CPU. This is intended, because the PPU paces its own requests.

## Structure
- Shared package `ppu_pkg` contains:
  - the `PPUState` enum (HBlank=0, VBlank=1, OAMScan=2, Draw=3), reused by the PPU;
  - region constants VRAM_BASE/VRAM_END and OAM_BASE/OAM_END;
  - the requester-id enum {REQ_PPU, REQ_DMA, REQ_CPU}.
- Sub-module `vmem_resp_pipe` holds the parameterised tag delay line and the response demux.

## Test plan
- PPU read of $8000 holding 8'h3C with no contention -> `ppu_gnt_out` at G, `ppu_valid_out`=1 with data 8'h3C at G+2.
- PPU, DMA and CPU all request in the same clock -> grants are issued to PPU, then DMA, then CPU on three consecutive clocks; memory writes happen only for DMA.
- CPU read of $FE10 with lcd_en=1 and mode=2 -> granted, `mem_en_out`=0, `cpu_valid_out` with 8'hFF at G+2. The same read with mode=0 returns the memory contents.
- CPU write of 8'hAA to $9000 with mode=3 -> dropped; a later read in mode 1 returns the old value. With lcd_en=0 the write lands.
- CPU read of $C000 -> completes with 8'hFF and the memory port is untouched.
- Assert `rst_in` one clock after a PPU grant -> no `ppu_valid_out` pulse; all outputs read their reset values on the next clock.

Source files
------------

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_pkg
// Description : Shared PPU types, video-memory region bounds and requester ids.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

   typedef enum logic [1:0] {
      HBlank  = 2'd0,
      VBlank  = 2'd1,
      OAMScan = 2'd2,
      Draw    = 2'd3
   } PPUState;

   localparam logic [15:0] VRAM_BASE = 16'h8000;
   localparam logic [15:0] VRAM_END  = 16'h9FFF;
   localparam logic [15:0] OAM_BASE  = 16'hFE00;
   localparam logic [15:0] OAM_END   = 16'hFE9F;

   typedef enum logic [1:0] {
      REQ_PPU = 2'd0,
      REQ_DMA = 2'd1,
      REQ_CPU = 2'd2
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    blocked;
   } resp_tag_t;

   function automatic logic in_region(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] last);
      return (addr >= base) && (addr <= last);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vmem_resp_pipe
// Description : Tag delay line matching memory latency, plus response demux.
// Revision    : 1.0 - initial release
// ============================================================================
module vmem_resp_pipe
   import ppu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk_in,
   input  logic      rst_in,
   input  resp_tag_t i_tag,
   input  logic [7:0] i_rdata,
   output logic       o_ppu_valid,
   output logic [7:0] o_ppu_data,
   output logic       o_cpu_valid,
   output logic [7:0] o_cpu_data
);

   localparam logic [7:0] c_BLOCKED_DATA = 8'hFF;

   resp_tag_t  r_tag [DEPTH];
   resp_tag_t  w_exit;
   logic [7:0] w_cpu_rdata;
   logic [7:0] r_ppu_hold;
   logic [7:0] r_cpu_hold;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   // Data is passed straight through on the valid clock, since memory read
   // data is only present during that clock; the hold registers keep it after.
   always_comb begin
      w_exit      = r_tag[DEPTH-1];
      o_ppu_valid = w_exit.valid && (w_exit.id == REQ_PPU);
      o_cpu_valid = w_exit.valid && (w_exit.id == REQ_CPU);
      w_cpu_rdata = w_exit.blocked ? c_BLOCKED_DATA : i_rdata;
      o_ppu_data  = o_ppu_valid ? i_rdata : r_ppu_hold;
      o_cpu_data  = o_cpu_valid ? w_cpu_rdata : r_cpu_hold;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_ppu_hold <= 8'h00;
         r_cpu_hold <= 8'h00;
      end else begin
         if (o_ppu_valid) r_ppu_hold <= i_rdata;
         if (o_cpu_valid) r_cpu_hold <= w_cpu_rdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vmem_arbiter
// Description : Fixed-priority PPU/DMA/CPU arbiter for the video-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module vmem_arbiter
   import ppu_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [1:0]  mode_in,
   input  logic        lcd_en_in,
   input  logic        dma_active_in,
   input  logic        ppu_req_in,
   input  logic [15:0] ppu_addr_in,
   output logic        ppu_gnt_out,
   output logic        ppu_valid_out,
   output logic [7:0]  ppu_data_out,
   input  logic        dma_req_in,
   input  logic [15:0] dma_addr_in,
   input  logic [7:0]  dma_wdata_in,
   output logic        dma_gnt_out,
   input  logic        cpu_req_in,
   input  logic        cpu_we_in,
   input  logic [15:0] cpu_addr_in,
   input  logic [7:0]  cpu_wdata_in,
   output logic        cpu_gnt_out,
   output logic        cpu_valid_out,
   output logic [7:0]  cpu_data_out,
   output logic        mem_en_out,
   output logic        mem_we_out,
   output logic [15:0] mem_addr_out,
   output logic [7:0]  mem_wdata_out,
   input  logic [7:0]  mem_rdata_in
);

   logic      w_ppu_req, w_dma_req, w_cpu_req;
   logic      w_cpu_in_vram, w_cpu_in_oam;
   logic      w_oam_locked, w_vram_locked, w_cpu_blocked;
   PPUState   w_mode;

   logic        r_ppu_gnt, r_dma_gnt, r_cpu_gnt;
   logic        r_mem_en, r_mem_we;
   logic [15:0] r_mem_addr;
   logic [7:0]  r_mem_wdata;
   resp_tag_t   r_push;

   // A registered requester still holds req during its grant clock; masking
   // it there prevents a second grant for the same transfer.
   assign w_ppu_req = ppu_req_in & ~r_ppu_gnt;
   assign w_dma_req = dma_req_in & ~r_dma_gnt;
   assign w_cpu_req = cpu_req_in & ~r_cpu_gnt;

   always_comb begin
      w_mode        = PPUState'(mode_in);
      w_cpu_in_vram = in_region(cpu_addr_in, VRAM_BASE, VRAM_END);
      w_cpu_in_oam  = in_region(cpu_addr_in, OAM_BASE, OAM_END);
      w_oam_locked  = (w_mode == OAMScan) || (w_mode == Draw) || dma_active_in;
      w_vram_locked = (w_mode == Draw);
      w_cpu_blocked = !(w_cpu_in_vram || w_cpu_in_oam) ||
                      (lcd_en_in && ((w_cpu_in_oam  && w_oam_locked) ||
                                     (w_cpu_in_vram && w_vram_locked)));
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_ppu_gnt   <= 1'b0;
         r_dma_gnt   <= 1'b0;
         r_cpu_gnt   <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 8'h00;
         r_push      <= '0;
      end else begin
         r_ppu_gnt <= 1'b0;
         r_dma_gnt <= 1'b0;
         r_cpu_gnt <= 1'b0;
         r_mem_en  <= 1'b0;
         r_mem_we  <= 1'b0;
         r_push    <= '0;
         if (w_ppu_req) begin
            r_ppu_gnt  <= 1'b1;
            r_mem_en   <= 1'b1;
            r_mem_addr <= ppu_addr_in;
            r_push     <= '{valid: 1'b1, id: REQ_PPU, blocked: 1'b0};
         end else if (w_dma_req) begin
            r_dma_gnt   <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= dma_addr_in;
            r_mem_wdata <= dma_wdata_in;
            r_push      <= '{valid: 1'b1, id: REQ_DMA, blocked: 1'b0};
         end else if (w_cpu_req) begin
            r_cpu_gnt <= 1'b1;
            r_push    <= '{valid: 1'b1, id: REQ_CPU, blocked: w_cpu_blocked};
            // A blocked access leaves the memory port completely idle
            if (!w_cpu_blocked) begin
               r_mem_en    <= 1'b1;
               r_mem_we    <= cpu_we_in;
               r_mem_addr  <= cpu_addr_in;
               r_mem_wdata <= cpu_wdata_in;
            end
         end
      end
   end

   assign ppu_gnt_out   = r_ppu_gnt;
   assign dma_gnt_out   = r_dma_gnt;
   assign cpu_gnt_out   = r_cpu_gnt;
   assign mem_en_out    = r_mem_en;
   assign mem_we_out    = r_mem_we;
   assign mem_addr_out  = r_mem_addr;
   assign mem_wdata_out = r_mem_wdata;

   vmem_resp_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_resp_pipe (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .i_tag       (r_push),
      .i_rdata     (mem_rdata_in),
      .o_ppu_valid (ppu_valid_out),
      .o_ppu_data  (ppu_data_out),
      .o_cpu_valid (cpu_valid_out),
      .o_cpu_data  (cpu_data_out)
   );

endmodule
`default_nettype wire

// File: tb/tb_vmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmem_arbiter
// Description : Directed plus randomized bench for vmem_arbiter with a
//               transaction-level reference model and a BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmem_arbiter;

   localparam int LAT = 2;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [1:0]  mode_in;
   logic        lcd_en_in, dma_active_in;
   logic        ppu_req_in;
   logic [15:0] ppu_addr_in;
   logic        ppu_gnt_out, ppu_valid_out;
   logic [7:0]  ppu_data_out;
   logic        dma_req_in;
   logic [15:0] dma_addr_in;
   logic [7:0]  dma_wdata_in;
   logic        dma_gnt_out;
   logic        cpu_req_in, cpu_we_in;
   logic [15:0] cpu_addr_in;
   logic [7:0]  cpu_wdata_in;
   logic        cpu_gnt_out, cpu_valid_out;
   logic [7:0]  cpu_data_out;
   logic        mem_en_out, mem_we_out;
   logic [15:0] mem_addr_out;
   logic [7:0]  mem_wdata_out;
   logic [7:0]  mem_rdata_in;

   always #5 clk_in = ~clk_in;

   vmem_arbiter #(.MEM_LATENCY(LAT)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mode_in(mode_in), .lcd_en_in(lcd_en_in),
      .dma_active_in(dma_active_in),
      .ppu_req_in(ppu_req_in), .ppu_addr_in(ppu_addr_in), .ppu_gnt_out(ppu_gnt_out),
      .ppu_valid_out(ppu_valid_out), .ppu_data_out(ppu_data_out),
      .dma_req_in(dma_req_in), .dma_addr_in(dma_addr_in), .dma_wdata_in(dma_wdata_in),
      .dma_gnt_out(dma_gnt_out),
      .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in), .cpu_addr_in(cpu_addr_in),
      .cpu_wdata_in(cpu_wdata_in), .cpu_gnt_out(cpu_gnt_out),
      .cpu_valid_out(cpu_valid_out), .cpu_data_out(cpu_data_out),
      .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
      .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
   );

   function automatic logic [7:0] init_val(int a);
      if (a == 32'h8000) return 8'h3C;
      return 8'((a * 37) ^ (a >> 7));
   endfunction

   // BRAM: read-before-write, data appears LAT clocks after the address
   logic [7:0] bram [65536];
   logic [7:0] rd_pipe [LAT];
   bit         bram_ready = 1'b0;
   always @(posedge clk_in) begin
      if (!bram_ready) begin
         for (int i = 0; i < 65536; i++) bram[i] <= init_val(i);
         bram_ready <= 1'b1;
      end else if (mem_en_out && mem_we_out) begin
         bram[mem_addr_out] <= mem_wdata_out;
      end
      rd_pipe[0] <= bram[mem_addr_out];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata_in = rd_pipe[LAT-1];

   // Reference model state
   typedef struct { int due; bit to_cpu; logic [7:0] data; } exp_t;
   exp_t       exp_q[$];
   logic [7:0] shadow [65536];
   logic [7:0] last_ppu, last_cpu;
   bit         granted_ppu, granted_dma, granted_cpu;
   int         checks = 0, errors = 0, cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit cpu_blocked_ref(logic [15:0] a, bit lcd, int mode, bit dma);
      bit vram, oam;
      vram = (a >= 16'h8000) && (a <= 16'h9FFF);
      oam  = (a >= 16'hFE00) && (a <= 16'hFE9F);
      if (!vram && !oam) return 1'b1;
      if (!lcd) return 1'b0;
      if (oam) return (mode >= 2) || dma;
      return mode == 3;
   endfunction

   task automatic step();
      int         win;
      bit         blk, rst_s, exp_pv, exp_cv;
      logic [7:0] rsp;
      exp_t       e;
      rst_s = rst_in;
      win   = 0;
      if (!rst_s) begin
         if (ppu_req_in) win = 1;
         else if (dma_req_in) win = 2;
         else if (cpu_req_in) win = 3;
      end
      blk = cpu_blocked_ref(cpu_addr_in, lcd_en_in, int'(mode_in), dma_active_in);
      @(posedge clk_in); #1;
      cyc++;
      granted_ppu = 1'b0; granted_dma = 1'b0; granted_cpu = 1'b0;
      if (rst_s) begin
         exp_q.delete();
         last_ppu = 8'h00;
         last_cpu = 8'h00;
         check_val("rst_mem_addr", 32'(mem_addr_out), 32'h0);
      end
      check_val("ppu_gnt", 32'(ppu_gnt_out), 32'(win == 1));
      check_val("dma_gnt", 32'(dma_gnt_out), 32'(win == 2));
      check_val("cpu_gnt", 32'(cpu_gnt_out), 32'(win == 3));
      case (win)
         1: begin
            check_val("ppu_mem_en", 32'(mem_en_out), 32'h1);
            check_val("ppu_mem_we", 32'(mem_we_out), 32'h0);
            check_val("ppu_mem_addr", 32'(mem_addr_out), 32'(ppu_addr_in));
         end
         2: begin
            check_val("dma_mem_en", 32'(mem_en_out), 32'h1);
            check_val("dma_mem_we", 32'(mem_we_out), 32'h1);
            check_val("dma_mem_addr", 32'(mem_addr_out), 32'(dma_addr_in));
            check_val("dma_mem_wdata", 32'(mem_wdata_out), 32'(dma_wdata_in));
         end
         3: begin
            check_val("cpu_mem_en", 32'(mem_en_out), 32'(!blk));
            if (blk) begin
               check_val("cpu_blk_mem_we", 32'(mem_we_out), 32'h0);
            end else begin
               check_val("cpu_mem_we", 32'(mem_we_out), 32'(cpu_we_in));
               check_val("cpu_mem_addr", 32'(mem_addr_out), 32'(cpu_addr_in));
               if (cpu_we_in) check_val("cpu_mem_wdata", 32'(mem_wdata_out), 32'(cpu_wdata_in));
            end
         end
         default: begin
            check_val("idle_mem_en", 32'(mem_en_out), 32'h0);
            check_val("idle_mem_we", 32'(mem_we_out), 32'h0);
         end
      endcase
      exp_pv = 1'b0;
      exp_cv = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         if (e.to_cpu) begin exp_cv = 1'b1; last_cpu = e.data; end
         else          begin exp_pv = 1'b1; last_ppu = e.data; end
      end
      check_val("ppu_valid", 32'(ppu_valid_out), 32'(exp_pv));
      check_val("cpu_valid", 32'(cpu_valid_out), 32'(exp_cv));
      check_val("ppu_data", 32'(ppu_data_out), 32'(last_ppu));
      check_val("cpu_data", 32'(cpu_data_out), 32'(last_cpu));
      case (win)
         1: begin
            exp_q.push_back('{due: cyc + LAT, to_cpu: 1'b0, data: shadow[ppu_addr_in]});
            ppu_req_in  = 1'b0;
            granted_ppu = 1'b1;
         end
         2: begin
            shadow[dma_addr_in] = dma_wdata_in;
            dma_req_in  = 1'b0;
            granted_dma = 1'b1;
         end
         3: begin
            rsp = blk ? 8'hFF : shadow[cpu_addr_in];
            if (!blk && cpu_we_in) shadow[cpu_addr_in] = cpu_wdata_in;
            exp_q.push_back('{due: cyc + LAT, to_cpu: 1'b1, data: rsp});
            cpu_req_in  = 1'b0;
            granted_cpu = 1'b1;
         end
         default: ;
      endcase
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d);
      cpu_req_in = 1'b1; cpu_we_in = we; cpu_addr_in = a; cpu_wdata_in = d;
      run(LAT + 2);
   endtask

   function automatic logic [15:0] rand_addr(bit allow_outside);
      case ($urandom_range(0, allow_outside ? 9 : 5))
         0:       return 16'h8000 + 16'($urandom_range(0, 7));
         1:       return 16'h9FFF;
         2:       return 16'h9FF8 + 16'($urandom_range(0, 7));
         3:       return 16'hFE00 + 16'($urandom_range(0, 7));
         4:       return 16'hFE9F;
         5:       return 16'hFE98 + 16'($urandom_range(0, 7));
         6:       return 16'h7FFF;
         7:       return 16'hA000;
         8:       return 16'hFEA0;
         default: return 16'hC000;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
      rst_in = 1'b1; mode_in = 2'd0; lcd_en_in = 1'b1; dma_active_in = 1'b0;
      ppu_req_in = 1'b0; ppu_addr_in = 16'h0; dma_req_in = 1'b0; dma_addr_in = 16'h0;
      dma_wdata_in = 8'h0; cpu_req_in = 1'b0; cpu_we_in = 1'b0; cpu_addr_in = 16'h0;
      cpu_wdata_in = 8'h0;
      last_ppu = 8'h00; last_cpu = 8'h00;
      run(2);
      rst_in = 1'b0;

      // Uncontended PPU read of $8000 (holds 8'h3C)
      ppu_req_in = 1'b1; ppu_addr_in = 16'h8000;
      run(LAT + 2);

      // Three-way contention: PPU, then DMA, then CPU
      ppu_req_in = 1'b1; ppu_addr_in = 16'h8001;
      dma_req_in = 1'b1; dma_addr_in = 16'hFE05; dma_wdata_in = 8'h5A;
      cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'h8002;
      run(LAT + 4);

      // OAM read locked in mode 2, open in mode 0
      mode_in = 2'd2; cpu_access(1'b0, 16'hFE10, 8'h00);
      mode_in = 2'd0; cpu_access(1'b0, 16'hFE10, 8'h00);

      // VRAM write dropped in mode 3, lands with LCD off
      mode_in = 2'd3; cpu_access(1'b1, 16'h9000, 8'hAA);
      mode_in = 2'd1; cpu_access(1'b0, 16'h9000, 8'h00);
      lcd_en_in = 1'b0; mode_in = 2'd3; cpu_access(1'b1, 16'h9000, 8'hAA);
      lcd_en_in = 1'b1; mode_in = 2'd1; cpu_access(1'b0, 16'h9000, 8'h00);

      // Outside both regions
      cpu_access(1'b0, 16'hC000, 8'h00);

      // Reset right after a PPU grant drops the response
      ppu_req_in = 1'b1; ppu_addr_in = 16'h8000;
      run(1);
      rst_in = 1'b1;
      run(1);
      rst_in = 1'b0;
      run(LAT + 2);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (!ppu_req_in && !granted_ppu && $urandom_range(0, 3) == 0) begin
            ppu_req_in = 1'b1; ppu_addr_in = rand_addr(1'b0);
         end
         if (!dma_req_in && !granted_dma && $urandom_range(0, 2) == 0) begin
            dma_req_in = 1'b1; dma_addr_in = 16'hFE00 + 16'($urandom_range(0, 15));
            dma_wdata_in = 8'($urandom);
         end
         if (!cpu_req_in && !granted_cpu && $urandom_range(0, 1) == 0) begin
            cpu_req_in = 1'b1; cpu_we_in = 1'($urandom_range(0, 1));
            cpu_addr_in = rand_addr(1'b1); cpu_wdata_in = 8'($urandom);
         end
         if ($urandom_range(0, 7) == 0) mode_in = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) lcd_en_in = ~lcd_en_in;
         if ($urandom_range(0, 7) == 0) dma_active_in = 1'($urandom_range(0, 1));
         rst_in = (n == 1500);
         step();
      end
      rst_in = 1'b0;
      ppu_req_in = 1'b0; dma_req_in = 1'b0; cpu_req_in = 1'b0;
      run(LAT + 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
